// File: rtl/rastreador_posicao.sv
`default_nettype none
// ============================================================================
// Module   : rastreador_posicao
// Brief    : Integrates acao step codes into an (x,y) grid position, flags
//            wall collisions, counts steps/collisions, tracks target arrival.
// Revision : 1.0 - initial release
// ============================================================================
module rastreador_posicao #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int CW     = 3,
    parameter int X0     = 0,
    parameter int Y0     = 0,
    parameter int SW     = 8
) (
    input  logic          c4,
    input  logic          reset,
    input  logic [2:0]    acao,
    input  logic          alvo_valido,
    input  logic [CW-1:0] alvo_x,
    input  logic [CW-1:0] alvo_y,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          colisao,
    output logic          chegou,
    output logic          erro,
    output logic [SW-1:0] passos,
    output logic [SW-1:0] colisoes,
    output logic [1:0]    estado
);

    localparam logic [2:0]    c_parado = 3'b000;
    localparam logic [2:0]    c_norte  = 3'b001;
    localparam logic [2:0]    c_oeste  = 3'b010;
    localparam logic [2:0]    c_leste  = 3'b011;
    localparam logic [2:0]    c_sul    = 3'b100;
    localparam logic [CW-1:0] c_max_x  = CW'(GRID_W - 1);
    localparam logic [CW-1:0] c_max_y  = CW'(GRID_H - 1);
    localparam logic [CW-1:0] c_x0     = CW'(X0);
    localparam logic [CW-1:0] c_y0     = CW'(Y0);
    localparam logic [CW:0]   c_grid_w = (CW+1)'(GRID_W);
    localparam logic [CW:0]   c_grid_h = (CW+1)'(GRID_H);

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        NAVEGANDO = 2'b01,
        CHEGOU    = 2'b10
    } t_estado;

    t_estado       r_estado;
    t_estado       w_estado_prox;
    logic [CW-1:0] r_pos_x;
    logic [CW-1:0] r_pos_y;
    logic [CW-1:0] r_alvo_x;
    logic [CW-1:0] r_alvo_y;
    logic [SW-1:0] r_passos;
    logic [SW-1:0] r_colisoes;
    logic          r_colisao;
    logic          r_erro;

    logic [CW-1:0] w_nx;
    logic [CW-1:0] w_ny;
    logic [CW-1:0] w_tx;
    logic [CW-1:0] w_ty;
    logic          w_move;
    logic          w_reject;
    logic          w_bad_code;
    logic          w_alvo_ok;
    logic          w_alvo_bad;
    logic          w_hit;

    // Step decode: next position, accepted/rejected move, illegal code
    always_comb begin
        w_nx       = r_pos_x;
        w_ny       = r_pos_y;
        w_move     = 1'b0;
        w_reject   = 1'b0;
        w_bad_code = 1'b0;
        case (acao)
            c_parado: ;
            c_norte: begin
                if (r_pos_y == c_max_y) w_reject = 1'b1;
                else begin
                    w_ny   = r_pos_y + CW'(1);
                    w_move = 1'b1;
                end
            end
            c_sul: begin
                if (r_pos_y == '0) w_reject = 1'b1;
                else begin
                    w_ny   = r_pos_y - CW'(1);
                    w_move = 1'b1;
                end
            end
            c_leste: begin
                if (r_pos_x == c_max_x) w_reject = 1'b1;
                else begin
                    w_nx   = r_pos_x + CW'(1);
                    w_move = 1'b1;
                end
            end
            c_oeste: begin
                if (r_pos_x == '0) w_reject = 1'b1;
                else begin
                    w_nx   = r_pos_x - CW'(1);
                    w_move = 1'b1;
                end
            end
            default: w_bad_code = 1'b1;
        endcase
    end

    // A freshly loaded target takes effect in the same cycle as its strobe
    assign w_alvo_ok  = alvo_valido && ({1'b0, alvo_x} < c_grid_w)
                                    && ({1'b0, alvo_y} < c_grid_h);
    assign w_alvo_bad = alvo_valido && !w_alvo_ok;
    assign w_tx       = w_alvo_ok ? alvo_x : r_alvo_x;
    assign w_ty       = w_alvo_ok ? alvo_y : r_alvo_y;
    assign w_hit      = (w_nx == w_tx) && (w_ny == w_ty);

    always_comb begin
        w_estado_prox = r_estado;
        case (r_estado)
            OCIOSO:    if (w_alvo_ok) w_estado_prox = w_hit ? CHEGOU : NAVEGANDO;
            NAVEGANDO: if (w_hit) w_estado_prox = CHEGOU;
            CHEGOU:    if (!w_hit) w_estado_prox = NAVEGANDO;
            default:   w_estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge c4 or posedge reset) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_pos_x    <= c_x0;
            r_pos_y    <= c_y0;
            r_alvo_x   <= '0;
            r_alvo_y   <= '0;
            r_passos   <= '0;
            r_colisoes <= '0;
            r_colisao  <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_estado  <= w_estado_prox;
            r_pos_x   <= w_nx;
            r_pos_y   <= w_ny;
            r_colisao <= w_reject;
            if (w_alvo_ok) begin
                r_alvo_x <= alvo_x;
                r_alvo_y <= alvo_y;
            end
            if (w_move && (r_passos != '1))
                r_passos <= r_passos + SW'(1);
            if (w_reject && (r_colisoes != '1))
                r_colisoes <= r_colisoes + SW'(1);
            if (w_bad_code || w_alvo_bad)
                r_erro <= 1'b1;
        end
    end

    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign colisao  = r_colisao;
    assign chegou   = (r_estado == CHEGOU);
    assign erro     = r_erro;
    assign passos   = r_passos;
    assign colisoes = r_colisoes;
    assign estado   = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_rastreador_posicao.sv
`default_nettype none
// ============================================================================
// Module   : tb_rastreador_posicao
// Brief    : Directed table-driven bench for rastreador_posicao (CW=4 so that
//            out-of-grid targets are representable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rastreador_posicao;

    localparam int CW = 4;
    localparam int SW = 8;

    logic          c4 = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    acao = 3'd0;
    logic          alvo_valido = 1'b0;
    logic [CW-1:0] alvo_x = '0;
    logic [CW-1:0] alvo_y = '0;
    logic [CW-1:0] pos_x;
    logic [CW-1:0] pos_y;
    logic          colisao;
    logic          chegou;
    logic          erro;
    logic [SW-1:0] passos;
    logic [SW-1:0] colisoes;
    logic [1:0]    estado;

    int n_checks = 0;
    int n_errors = 0;

    rastreador_posicao #(
        .GRID_W(8), .GRID_H(8), .CW(CW), .X0(0), .Y0(0), .SW(SW)
    ) dut (
        .c4(c4), .reset(reset), .acao(acao), .alvo_valido(alvo_valido),
        .alvo_x(alvo_x), .alvo_y(alvo_y), .pos_x(pos_x), .pos_y(pos_y),
        .colisao(colisao), .chegou(chegou), .erro(erro), .passos(passos),
        .colisoes(colisoes), .estado(estado)
    );

    always #5 c4 = ~c4;

    typedef struct {
        logic          rst;
        logic [2:0]    acao;
        logic          av;
        logic [CW-1:0] ax, ay;
        logic [CW-1:0] ex, ey;
        logic          ecol, ech, eerr;
        logic [SW-1:0] ep, ec;
        logic [1:0]    est;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] a);
        acao        = a;
        alvo_valido = 1'b0;
        @(negedge c4);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //          rst acao av ax ay | ex ey col ch err passos col est
        tbl[0]  = '{1, 3'd0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 2'd0};
        tbl[1]  = '{0, 3'd1, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0, 2'd0};
        tbl[2]  = '{0, 3'd1, 0, 0, 0,   0, 2, 0, 0, 0, 2, 0, 2'd0};
        tbl[3]  = '{0, 3'd1, 0, 0, 0,   0, 3, 0, 0, 0, 3, 0, 2'd0};
        tbl[4]  = '{1, 3'd2, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 2'd0};
        tbl[5]  = '{0, 3'd0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 2'd0};
        tbl[6]  = '{0, 3'd0, 1, 2, 1,   0, 0, 0, 0, 0, 0, 1, 2'd1};
        tbl[7]  = '{0, 3'd3, 0, 0, 0,   1, 0, 0, 0, 0, 1, 1, 2'd1};
        tbl[8]  = '{0, 3'd3, 0, 0, 0,   2, 0, 0, 0, 0, 2, 1, 2'd1};
        tbl[9]  = '{0, 3'd1, 0, 0, 0,   2, 1, 0, 1, 0, 3, 1, 2'd2};
        tbl[10] = '{0, 3'd4, 0, 0, 0,   2, 0, 0, 0, 0, 4, 1, 2'd1};
        tbl[11] = '{0, 3'd1, 0, 0, 0,   2, 1, 0, 1, 0, 5, 1, 2'd2};
        tbl[12] = '{0, 3'd0, 1, 9, 0,   2, 1, 0, 1, 1, 5, 1, 2'd2};
        tbl[13] = '{0, 3'd6, 0, 0, 0,   2, 1, 0, 1, 1, 5, 1, 2'd2};
        tbl[14] = '{0, 3'd7, 1, 0, 8,   2, 1, 0, 1, 1, 5, 1, 2'd2};
        tbl[15] = '{0, 3'd3, 0, 0, 0,   3, 1, 0, 0, 1, 6, 1, 2'd1};
        tbl[16] = '{0, 3'd2, 0, 0, 0,   2, 1, 0, 1, 1, 7, 1, 2'd2};
        tbl[17] = '{0, 3'd1, 1, 2, 2,   2, 2, 0, 1, 1, 8, 1, 2'd2};
        tbl[18] = '{0, 3'd0, 1, 0, 0,   2, 2, 0, 0, 1, 8, 1, 2'd1};
        tbl[19] = '{1, 3'd0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0, 2'd2};
        tbl[20] = '{0, 3'd4, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1, 2'd2};
        tbl[21] = '{0, 3'd1, 0, 0, 0,   0, 1, 0, 0, 0, 1, 1, 2'd1};
        tbl[22] = '{0, 3'd5, 0, 0, 0,   0, 1, 0, 0, 1, 1, 1, 2'd1};

        repeat (2) @(negedge c4);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) pulse_reset();
            acao        = tbl[i].acao;
            alvo_valido = tbl[i].av;
            alvo_x      = tbl[i].ax;
            alvo_y      = tbl[i].ay;
            @(negedge c4);
            check($sformatf("v%0d pos_x", i),    pos_x,    tbl[i].ex);
            check($sformatf("v%0d pos_y", i),    pos_y,    tbl[i].ey);
            check($sformatf("v%0d colisao", i),  colisao,  tbl[i].ecol);
            check($sformatf("v%0d chegou", i),   chegou,   tbl[i].ech);
            check($sformatf("v%0d erro", i),     erro,     tbl[i].eerr);
            check($sformatf("v%0d passos", i),   passos,   tbl[i].ep);
            check($sformatf("v%0d colisoes", i), colisoes, tbl[i].ec);
            check($sformatf("v%0d estado", i),   estado,   tbl[i].est);
        end

        // Far walls: walk to x=7 and y=7, then push past each
        pulse_reset();
        repeat (7) step(3'd3);
        check("east pos_x", pos_x, 7);
        check("east colisao idle", colisao, 0);
        step(3'd3);
        check("east wall pos_x", pos_x, 7);
        check("east wall colisao", colisao, 1);
        check("east wall colisoes", colisoes, 1);
        repeat (7) step(3'd1);
        check("north pos_y", pos_y, 7);
        step(3'd1);
        check("north wall pos_y", pos_y, 7);
        check("north wall colisao", colisao, 1);
        check("north wall colisoes", colisoes, 2);
        check("walls passos", passos, 14);
        check("walls estado", estado, 0);

        // Asynchronous reset mid-walk at (3,4) with a target loaded
        pulse_reset();
        acao = 3'd0; alvo_valido = 1'b1; alvo_x = 5; alvo_y = 5;
        @(negedge c4);
        repeat (3) step(3'd3);
        repeat (4) step(3'd1);
        check("walk pos_x", pos_x, 3);
        check("walk pos_y", pos_y, 4);
        check("walk estado", estado, 1);
        check("walk passos", passos, 7);
        #2 reset = 1'b1;
        #1;
        check("async pos_x", pos_x, 0);
        check("async pos_y", pos_y, 0);
        check("async passos", passos, 0);
        check("async colisoes", colisoes, 0);
        check("async estado", estado, 0);
        check("async erro", erro, 0);
        check("async chegou", chegou, 0);
        reset = 1'b0;
        @(negedge c4);

        // Counter saturation
        pulse_reset();
        for (int k = 0; k < 129; k++) begin
            step(3'd1);
            step(3'd4);
        end
        check("passos saturated", passos, 255);
        for (int k = 0; k < 257; k++) step(3'd2);
        check("colisoes saturated", colisoes, 255);
        check("sat pos_x", pos_x, 0);
        check("sat passos held", passos, 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rastreador_posicao.md
Name: rastreador_posicao

Overview:
- Consumer end of the movement command interface: samples the 3-bit `acao` code driven by the advance unit and integrates it into an (x,y) grid position.
- Detects wall collisions and counts successful steps and collisions.
- Tracks a loaded target cell and reports arrival.
- Sits downstream of the advance unit; its position outputs feed display/status logic.

Parameters:
- GRID_W, 8, grid width in cells; x range 0..GRID_W-1
- GRID_H, 8, grid height in cells; y range 0..GRID_H-1
- CW, 3, coordinate width; must satisfy 2^CW >= max(GRID_W, GRID_H)
- X0, 0, x coordinate after reset
- Y0, 0, y coordinate after reset
- SW, 8, width of the step and collision counters

Ports:
- c4  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- acao  input  3  movement code: 000 parado, 001 N, 010 O, 011 L, 100 S
- alvo_valido  input  1  one-cycle strobe that loads alvo_x/alvo_y
- alvo_x  input  CW  target x
- alvo_y  input  CW  target y
- pos_x  output  CW  current x (registered)
- pos_y  output  CW  current y (registered)
- colisao  output  1  one-cycle pulse: move rejected at a wall
- chegou  output  1  high while state = CHEGOU
- erro  output  1  sticky error flag
- passos  output  SW  successful-move count, saturating
- colisoes  output  SW  rejected-move count, saturating
- estado  output  2  FSM state: 00 OCIOSO, 01 NAVEGANDO, 10 CHEGOU

Behaviour:
- Reset values, applied asynchronously: pos = (X0,Y0), passos = 0, colisoes = 0, colisao = 0, erro = 0, chegou = 0, estado = OCIOSO, stored target = (0,0).
- `acao` is sampled every c4 rising edge. Each edge with a nonzero valid code is exactly one step request; the upstream unit guarantees one cycle per step.
- Step request direction:
  - N: y+1
  - S: y-1
  - L: x+1
  - O: x-1
- Boundary handling:
  - N at y = GRID_H-1, S at y = 0, L at x = GRID_W-1, O at x = 0 are rejected.
  - On rejection: position unchanged, colisao = 1 for that cycle only, colisoes += 1.
- A successful step updates pos_x/pos_y at that edge (latency 1 cycle) and increments passos.
- Counters saturate at 2^SW-1 and never wrap.
- Codes 101/110/111 are treated as parado (no move, no count) and set erro. erro clears only on reset.
- Target load (alvo_valido = 1):
  - If alvo_x >= GRID_W or alvo_y >= GRID_H: target not stored, erro set, estado unchanged.
  - Otherwise: store the target and evaluate arrival in the same cycle.
- Arrival compare: next-cycle position vs effective target. The effective target is the newly loaded one if loading this cycle, else the stored one.
- FSM transitions:
  - OCIOSO -> NAVEGANDO on valid load when next pos != target.
  - OCIOSO -> CHEGOU on valid load when next pos == target.
  - NAVEGANDO -> CHEGOU when next pos == target.
  - CHEGOU -> NAVEGANDO when a successful step moves off the target, or a new valid target != next pos is loaded.
  - CHEGOU stays CHEGOU on parado or a rejected step.
  - No return to OCIOSO except via reset.
- Moves are accepted in every state; position tracking does not depend on the FSM.
- Simultaneous valid step and target load in one cycle: the step is applied first, then arrival is checked against the new target.
- Reset mid-operation: all state returns to the reset values immediately; the target is discarded.

Test Plan:
- Reset, then acao = 001 for 3 cycles -> pos (0,3), passos = 3, estado OCIOSO, colisao never 1.
- From (0,0), acao = 010 one cycle -> pos stays (0,0), colisao pulses 1 cycle, colisoes = 1, passos = 0.
- Load target (2,1) via alvo_valido, then drive L, L, N -> estado 01 after load; chegou = 1 the cycle after the N step; pos (2,1); passos = 3.
- In CHEGOU at (2,1), drive S -> pos (2,0), estado NAVEGANDO, chegou = 0. Drive N -> CHEGOU again.
- Load target (9,0) with GRID_W = 8 -> erro = 1, estado and stored target unchanged. Drive acao = 110 -> no move, erro stays 1 until reset.
- Assert reset asynchronously mid-walk at (3,4) with target loaded -> pos (0,0), counters 0, estado OCIOSO, erro 0 before the next c4 edge.
